debounce_multi: RTL and testbench

Parametrised multi-channel debouncer for board push-buttons and switches. It contains one shared prescaler, which produces a sample tick and a legacy square-wave debounce clock. Each channel has its own synchroniser and stability counter, and presents a clean level plus one-cycle rise/fall strobes in the clk domain. It sits between the raw board inputs and the CPU I/O and control logic, and replaces the free-running divider-only debounce clock.

---
 rtl/debounce_multi_pkg.sv | 22 ++
 rtl/debounce_chan.sv | 82 ++++++++
 rtl/debounce_multi.sv | 76 +++++++
 tb/tb_debounce_multi.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/debounce_multi_pkg.sv
// Shared constants, counter-action encoding and width helper for the multi-channel debouncer.
package debounce_multi_pkg;

   localparam int DEBOUNCE_TICK_DIV     = 500000;
   localparam int DEBOUNCE_STABLE_TICKS = 4;

   typedef enum logic [1:0] {
      CNT_CLEAR,
      CNT_QUALIFY,
      CNT_ADVANCE,
      CNT_HOLD
   } cnt_action_e;

   // Bits needed to hold 0..value-1; never narrower than one bit.
   function automatic int clog2(input int value);
      int w;
      w = 1;
      while ((1 << w) < value) w++;
      return w;
   endfunction

endpackage

// File: rtl/debounce_chan.sv
// One debounce channel: input synchroniser, stability counter and registered level/edge strobes.
module debounce_chan
   import debounce_multi_pkg::*;
#(
   parameter int   STABLE_TICKS = DEBOUNCE_STABLE_TICKS,
   parameter int   SYNC_STAGES  = 2,
   parameter logic INVERT       = 1'b0
) (
   input  logic clk_i,
   input  logic clr_ni,
   input  logic tick_i,
   input  logic raw_i,
   output logic db_o,
   output logic rise_o,
   output logic fall_o
);

   localparam int CW = clog2(STABLE_TICKS + 1);
   localparam logic [CW-1:0] CNT_LAST = CW'(STABLE_TICKS - 1);

   logic [SYNC_STAGES-1:0] sync_q, sync_d;
   logic [CW-1:0]          cnt_q, cnt_d;
   logic                   db_q, db_d;
   logic                   rise_q, rise_d;
   logic                   fall_q, fall_d;
   logic                   s;
   cnt_action_e            action;

   assign sync_d = {sync_q[SYNC_STAGES-2:0], raw_i ^ INVERT};
   assign s      = sync_q[SYNC_STAGES-1];

   // Agreement with the current level wins on any cycle, so one glitch back restarts the count.
   always_comb begin
      action = CNT_HOLD;
      if (s == db_q) begin
         action = CNT_CLEAR;
      end else if (tick_i && (cnt_q == CNT_LAST)) begin
         action = CNT_QUALIFY;
      end else if (tick_i) begin
         action = CNT_ADVANCE;
      end
   end

   always_comb begin
      cnt_d  = cnt_q;
      db_d   = db_q;
      rise_d = 1'b0;
      fall_d = 1'b0;
      unique case (action)
         CNT_CLEAR:   cnt_d = '0;
         CNT_QUALIFY: begin
            cnt_d  = '0;
            db_d   = s;
            rise_d = s;
            fall_d = ~s;
         end
         CNT_ADVANCE: cnt_d = cnt_q + CW'(1);
         CNT_HOLD:    cnt_d = cnt_q;
      endcase
   end

   always_ff @(posedge clk_i or negedge clr_ni) begin
      if (!clr_ni) begin
         sync_q <= '0;
         cnt_q  <= '0;
         db_q   <= 1'b0;
         rise_q <= 1'b0;
         fall_q <= 1'b0;
      end else begin
         sync_q <= sync_d;
         cnt_q  <= cnt_d;
         db_q   <= db_d;
         rise_q <= rise_d;
         fall_q <= fall_d;
      end
   end

   assign db_o   = db_q;
   assign rise_o = rise_q;
   assign fall_o = fall_q;

endmodule

// File: rtl/debounce_multi.sv
// Multi-channel debouncer: shared sample-tick prescaler with legacy square-wave clock, plus per-channel qualifiers.
module debounce_multi
   import debounce_multi_pkg::*;
#(
   parameter int                  CHANNELS     = 5,
   parameter int                  TICK_DIV     = DEBOUNCE_TICK_DIV,
   parameter int                  STABLE_TICKS = DEBOUNCE_STABLE_TICKS,
   parameter int                  SYNC_STAGES  = 2,
   parameter logic [CHANNELS-1:0] INVERT       = '0
) (
   input  logic                clk,
   input  logic                clr,
   input  logic                en,
   input  logic [CHANNELS-1:0] raw_in,
   output logic                tick,
   output logic                de_clk,
   output logic [CHANNELS-1:0] db_out,
   output logic [CHANNELS-1:0] rise,
   output logic [CHANNELS-1:0] fall
);

   localparam int PW = clog2(TICK_DIV);
   localparam logic [PW-1:0] PRE_LAST = PW'(TICK_DIV - 1);

   logic [PW-1:0] pre_q, pre_d;
   logic          tick_q, tick_d;
   logic          de_clk_q, de_clk_d;

   // Tick and de_clk are registered off the wrap so both change in the cycle after the terminal count.
   always_comb begin
      pre_d    = pre_q;
      tick_d   = 1'b0;
      de_clk_d = de_clk_q;
      if (en) begin
         if (pre_q == PRE_LAST) begin
            pre_d    = '0;
            tick_d   = 1'b1;
            de_clk_d = ~de_clk_q;
         end else begin
            pre_d = pre_q + PW'(1);
         end
      end
   end

   always_ff @(posedge clk or negedge clr) begin
      if (!clr) begin
         pre_q    <= '0;
         tick_q   <= 1'b0;
         de_clk_q <= 1'b0;
      end else begin
         pre_q    <= pre_d;
         tick_q   <= tick_d;
         de_clk_q <= de_clk_d;
      end
   end

   assign tick   = tick_q;
   assign de_clk = de_clk_q;

   for (genvar g = 0; g < CHANNELS; g++) begin : g_chan
      debounce_chan #(
         .STABLE_TICKS (STABLE_TICKS),
         .SYNC_STAGES  (SYNC_STAGES),
         .INVERT       (INVERT[g])
      ) u_chan (
         .clk_i  (clk),
         .clr_ni (clr),
         .tick_i (tick_q),
         .raw_i  (raw_in[g]),
         .db_o   (db_out[g]),
         .rise_o (rise[g]),
         .fall_o (fall[g])
      );
   end

endmodule

// File: tb/tb_debounce_multi.sv
// Directed and randomized bench for debounce_multi against a tick-counting reference model.
module tb_debounce_multi;

   localparam int         CH  = 2;
   localparam int         TD  = 4;
   localparam int         ST  = 3;
   localparam int         SS  = 2;
   localparam logic [1:0] INV = 2'b10;

   logic          clk = 1'b0;
   logic          clr = 1'b1;
   logic          en  = 1'b1;
   logic [CH-1:0] raw_in = 2'b10;
   logic          tick, de_clk;
   logic [CH-1:0] db_out, rise, fall;

   always #5 clk = ~clk;

   debounce_multi #(
      .CHANNELS     (CH),
      .TICK_DIV     (TD),
      .STABLE_TICKS (ST),
      .SYNC_STAGES  (SS),
      .INVERT       (INV)
   ) dut (
      .clk    (clk),
      .clr    (clr),
      .en     (en),
      .raw_in (raw_in),
      .tick   (tick),
      .de_clk (de_clk),
      .db_out (db_out),
      .rise   (rise),
      .fall   (fall)
   );

   int checks   = 0;
   int failures = 0;

   // Reference model: enabled-cycle count gives ticks, a running tick total per
   // channel measures how many ticks have passed since the input last agreed.
   int         m_nen;
   bit         m_tick, m_dclk;
   bit   [1:0] m_db, m_rise, m_fall;
   int         m_tot;
   int         m_snap [CH];
   bit   [1:0] hist [$];
   int         rise_seen [CH];
   int         fall_seen [CH];

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h t=%0t", tag, obs, exp, $time);
      end
   endtask

   function automatic void model_reset();
      m_nen  = 0;
      m_tick = 1'b0;
      m_dclk = 1'b0;
      m_db   = '0;
      m_rise = '0;
      m_fall = '0;
      m_tot  = 0;
      for (int c = 0; c < CH; c++) m_snap[c] = 0;
      hist.delete();
      for (int k = 0; k < SS; k++) hist.push_back(2'b00);
   endfunction

   function automatic int pending(input int c);
      return m_tot - m_snap[c];
   endfunction

   task automatic step();
      bit [1:0] s;
      int       tn;
      s  = hist[0];
      tn = m_tot + (m_tick ? 1 : 0);
      m_rise = '0;
      m_fall = '0;
      for (int c = 0; c < CH; c++) begin
         if (s[c] == m_db[c]) begin
            m_snap[c] = tn;
         end else if (m_tick && (tn - m_snap[c] == ST)) begin
            m_db[c]   = s[c];
            m_snap[c] = tn;
            m_rise[c] = s[c];
            m_fall[c] = !s[c];
         end
      end
      m_tot = tn;
      if (en) begin
         m_nen++;
         m_tick = ((m_nen % TD) == 0);
      end else begin
         m_tick = 1'b0;
      end
      if (m_tick) m_dclk = !m_dclk;
      hist.push_back(raw_in ^ INV);
      void'(hist.pop_front());
      @(posedge clk);
      #1;
      for (int c = 0; c < CH; c++) begin
         rise_seen[c] += int'(rise[c]);
         fall_seen[c] += int'(fall[c]);
      end
      chk("tick", tick, m_tick);
      chk("de_clk", de_clk, m_dclk);
      chk("db_out", db_out, m_db);
      chk("rise", rise, m_rise);
      chk("fall", fall, m_fall);
      chk("rise_fall_excl", rise & fall, 0);
   endtask

   task automatic clear_seen();
      for (int c = 0; c < CH; c++) begin
         rise_seen[c] = 0;
         fall_seen[c] = 0;
      end
   endtask

   task automatic do_reset(input int hold);
      clr = 1'b0;
      #1;
      model_reset();
      chk("rst_tick", tick, 0);
      chk("rst_de_clk", de_clk, 0);
      chk("rst_db", db_out, 0);
      chk("rst_rise", rise, 0);
      chk("rst_fall", fall, 0);
      for (int k = 0; k < hold; k++) begin
         @(posedge clk);
         #1;
         chk("rst_hold_db", db_out, 0);
         chk("rst_hold_tick", tick, 0);
         chk("rst_hold_strobe", rise | fall, 0);
      end
      clr = 1'b1;
   endtask

   initial begin
      int n;
      int ticks_in_freeze;
      int hold_t [CH];
      model_reset();
      clear_seen();
      #2;

      // 1: reset, tick cadence and de_clk
      do_reset(3);
      for (int c = 1; c <= 12; c++) begin
         step();
         chk("tick_cadence", tick, ((c % TD) == 0) ? 1 : 0);
         if (c == 4) chk("de_clk_after4", de_clk, 1);
         if (c == 8) chk("de_clk_after8", de_clk, 0);
      end

      // 2: clean press on channel 0
      clear_seen();
      raw_in = 2'b11;
      n = 0;
      while (!db_out[0] && n < 25) begin step(); n++; end
      chk("press_qualified", db_out[0], 1);
      chk("press_latency_ok", (n >= (ST-1)*TD+SS+1 && n <= ST*TD+SS+1) ? 1 : 0, 1);
      for (int k = 0; k < 6; k++) step();
      chk("press_rise_once", rise_seen[0], 1);
      chk("press_no_fall", fall_seen[0], 0);
      chk("press_ch1_quiet", rise_seen[1] + fall_seen[1], 0);
      chk("press_ch1_level", db_out[1], 0);

      // 3: bounce, then a clean hold
      raw_in = 2'b10;
      for (int k = 0; k < 20; k++) step();
      chk("bounce_pre_low", db_out[0], 0);
      clear_seen();
      for (int i = 0; i < 40; i++) begin
         raw_in[0] = ((i / 3) % 2 == 0) ? 1'b1 : 1'b0;
         step();
      end
      raw_in[0] = 1'b0;
      for (int k = 0; k < 10; k++) step();
      chk("bounce_level", db_out[0], 0);
      chk("bounce_no_rise", rise_seen[0], 0);
      chk("bounce_no_fall", fall_seen[0], 0);
      raw_in[0] = 1'b1;
      n = 0;
      while (!db_out[0] && n < 25) begin step(); n++; end
      chk("hold_after_bounce", db_out[0], 1);
      chk("hold_latency_ok", (n >= (ST-1)*TD+SS+1 && n <= ST*TD+SS+1) ? 1 : 0, 1);

      // 4: both channels high, then drop together
      raw_in = 2'b01;
      for (int k = 0; k < 20; k++) step();
      chk("both_high", db_out, 2'b11);
      raw_in = 2'b10;
      n = 0;
      while (fall == 2'b00 && n < 25) begin step(); n++; end
      chk("both_fall_same_cycle", fall, 2'b11);
      chk("both_low", db_out, 2'b00);
      step();
      chk("fall_one_cycle", fall, 2'b00);

      // 5: inverted channel held high through reset
      raw_in = 2'b10;
      do_reset(3);
      clear_seen();
      for (int k = 0; k < 20; k++) step();
      chk("inv_idle_level", db_out[1], 0);
      chk("inv_idle_no_rise", rise_seen[1], 0);
      raw_in[1] = 1'b0;
      n = 0;
      while (rise == 2'b00 && n < 25) begin step(); n++; end
      chk("inv_rise", rise, 2'b10);
      chk("inv_level", db_out[1], 1);

      // 6a: freeze with cnt=2
      raw_in[0] = 1'b1;
      n = 0;
      while (pending(0) != 2 && n < 30) begin step(); n++; end
      chk("freeze_reach_cnt2", pending(0), 2);
      en = 1'b0;
      ticks_in_freeze = 0;
      for (int k = 0; k < 12; k++) begin
         step();
         ticks_in_freeze += int'(tick);
         chk("freeze_db", db_out[0], 0);
      end
      chk("freeze_no_tick", ticks_in_freeze, 0);
      en = 1'b1;
      n = 0;
      while (!db_out[0] && n < TD + 4) begin step(); n++; end
      chk("freeze_resume", db_out[0], 1);
      chk("freeze_resume_next_tick", (n <= TD + 1) ? 1 : 0, 1);

      // 6b: clr pulse at cnt=2 aborts; held inputs re-qualify from zero
      raw_in[0] = 1'b0;
      for (int k = 0; k < 20; k++) step();
      chk("abort_pre_low", db_out[0], 0);
      raw_in[0] = 1'b1;
      n = 0;
      while (pending(0) != 2 && n < 30) begin step(); n++; end
      chk("abort_reach_cnt2", pending(0), 2);
      clear_seen();
      do_reset(2);
      n = 0;
      while (!db_out[0] && n < 25) begin step(); n++; end
      chk("requal_latency", n, ST*TD + 1);
      chk("requal_rise_both", rise, 2'b11);
      chk("requal_rise_count", rise_seen[0], 1);

      // Randomized phase
      for (int c = 0; c < CH; c++) hold_t[c] = 0;
      for (int i = 0; i < 900; i++) begin
         for (int c = 0; c < CH; c++) begin
            if (hold_t[c] == 0) begin
               raw_in[c] = 1'($urandom_range(0, 1));
               hold_t[c] = $urandom_range(1, 24);
            end else begin
               hold_t[c]--;
            end
         end
         if ($urandom_range(0, 29) == 0) en = ~en;
         else if (!en && $urandom_range(0, 3) == 0) en = 1'b1;
         if (i == 450) begin
            do_reset(2);
         end
         step();
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
